instruction_fetch: RTL
======================

# instruction_fetch

Instruction fetch stage for the MIPS datapath: the producer side of the opcode interface feeding the main control decoder. Maintains the PC and issues word addresses to a synchronous program ROM. Buffers returned words in a 2-entry skid FIFO and presents the IF/ID instruction register, whose bits [31:26] drive `OP` into the control unit. Consumes the decoder's `BranchEQ`/`BranchNE` outputs, together with the ALU `Zero` flag, to redirect and flush on taken branches.

## Interface
- `WORD_WIDTH`, 32, instruction and address width
- `RESET_PC`, 32'h0040_0000, first fetch address after reset
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `Stall`  in  1  hazard hold of the IF/ID register
- `BranchEQ`  in  1  from the control decoder
- `BranchNE`  in  1  from the control decoder
- `Zero`  in  1  ALU zero flag for the branch instruction
- `BranchTarget`  in  32  redirect address, word aligned
- `InstrAddr`  out  32  ROM read address, equals PC register
- `InstrData`  in  32  ROM read data, valid one cycle after address
- `Instruction`  out  32  IF/ID instruction word
- `PC_4`  out  32  address of `Instruction` + 4
- `InstrValid`  out  1  `Instruction` holds a real fetched word
- `OP`  out  6  `Instruction[31:26]`, wired to the control decoder

## Operation
- Taken = (`BranchEQ` & `Zero`) | (`BranchNE` & ~`Zero`).
- Issue condition: `fifo_count` + `inflight` < 2 and not Taken. When the condition holds, the current `InstrAddr` is a real request.
  - Set `inflight` for the next cycle.
  - PC <= PC + 4, modulo 2^32; 0xFFFFFFFC wraps to 0x00000000.
- Response: when `inflight` is 1, `InstrData` is paired with the request address + 4.
  - Bypass: if the FIFO is empty and the output register loads this cycle, the pair goes straight into the output register.
  - Otherwise the pair is pushed into the FIFO.
- Output register load condition: `Stall`=0 or `InstrValid`=0.
  - When loading, take the FIFO head, else the bypass pair.
  - If neither is available, load `Instruction`=0 (NOP) with `InstrValid`=0.
- With `Stall`=1 and `InstrValid`=1, `Instruction`, `PC_4` and `InstrValid` hold; the FIFO fills to 2, then issue stops. No word is lost or duplicated.
- Taken redirect: the PC captures `BranchTarget`, and a flush kills all prefetched work.
  - PC <= `BranchTarget`.
  - FIFO is cleared.
  - Any in-flight response arriving next cycle is discarded.
  - `InstrValid` <= 0 and `Instruction` <= 0.
- Priority: `reset` > Taken > `Stall`. A branch flushes even while stalled and with a full FIFO.
- Reset sets PC = `RESET_PC`, `inflight` = 0, `fifo_count` = 0, `Instruction` = 0, `PC_4` = 0, `InstrValid` = 0. Reset asserted mid-stream discards everything in flight.

## Timing
- Cycle 0 is the first cycle with `reset` low; `InstrAddr` = `RESET_PC` is issued.
- Cycle 1: data returns on `InstrData`.
- Cycle 2: `InstrValid` = 1 with that word.
- Steady state with `Stall` low: one instruction per cycle, through the bypass path.
- Branch Taken sampled in cycle t:
  - t+1: `InstrAddr` = target.
  - t+2: data returns.
  - t+3: target instruction valid.
  - t+1 and t+2 are bubbles with `InstrValid` = 0.
- Stall release: the FIFO head appears on the cycle after `Stall` falls. Issue resumes the same cycle a slot frees.

## Configuration
- `FETCH_STATS_EN` defined adds two outputs:
  - `FetchCount`[31:0]: counts words loaded into the output register with `InstrValid`=1.
  - `FlushCount`[15:0]: counts Taken cycles, saturating at 0xFFFF.
  - Both are cleared by `reset`.
- `FETCH_STATS_EN` undefined: the ports and counters are absent. Fetch behaviour is identical in both builds.

## Structure
- Package `mips_pkg` holds:
  - Opcode constants: `R_TYPE`=0, `ADDI`=6'h08, `ORI`=6'h0d, `BEQ`=6'h04, `BNE`=6'h05, `INC`=6'h01.
  - `NOP_WORD` = 32'h0.
  - Default `RESET_PC`.
- Sub-module `fetch_skid_fifo`: 2-entry, 64-bit {`PC_4`, word}.
  - Ports: push, pop, clear, count; synchronous clear.
  - Clear has priority over push.

## Test plan
- Reset release, `Stall`=0, ROM returns address as data:
  - `InstrAddr` goes 0x00400000, 0x00400004, 0x00400008.
  - Cycle 2: `Instruction`=0x00400000, `PC_4`=0x00400004, `InstrValid`=1.
  - One new word every cycle after that.
- `Stall`=1 for 4 cycles mid-stream:
  - Output holds.
  - `InstrAddr` advances at most 2 words beyond the held word.
  - After release, the sequence continues with no gaps or repeats.
- `BranchEQ`=1, `Zero`=1, `BranchTarget`=0x00400100 in cycle t:
  - `InstrValid`=0 at t+1 and t+2.
  - `Instruction` from 0x00400100 at t+3.
- `BranchNE`=1, `Zero`=1: no redirect, sequential fetch continues.
- Taken while `Stall`=1 with a full FIFO: FIFO cleared, target fetched, no stale word ever valid. Repeat with `reset` asserted mid-stream: all outputs return to reset values next cycle.
- `RESET_PC`=0xFFFFFFF8: addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; `PC_4` of the last word = 0x00000004.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS front-end constants: opcodes, NOP encoding, default fetch start address,
// and the branch-resolution helper used by the fetch stage.
package mips_pkg;

    localparam int WORD_W = 32;

    localparam logic [5:0] R_TYPE = 6'h00;
    localparam logic [5:0] ADDI   = 6'h08;
    localparam logic [5:0] ORI    = 6'h0d;
    localparam logic [5:0] BEQ    = 6'h04;
    localparam logic [5:0] BNE    = 6'h05;
    localparam logic [5:0] INC    = 6'h01;

    localparam logic [WORD_W-1:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0040_0000;

    function automatic logic branch_taken(input logic beq, input logic bne, input logic zero);
        return (beq & zero) | (bne & ~zero);
    endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid buffer of {PC_4, word} pairs; synchronous reset and clear, clear beats push.
// Push into a full buffer and pop from an empty one are ignored.
module fetch_skid_fifo #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_dat_i,
    input  logic              pop_i,
    input  logic              clear_i,
    output logic [DATA_W-1:0] head_dat_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic              rd_ptr_q;
    logic              wr_ptr_q;
    logic [1:0]        count_q;
    logic              push_ok;
    logic              pop_ok;

    assign push_ok    = push_i && !clear_i && (count_q != 2'd2);
    assign pop_ok     = pop_i && !clear_i && (count_q != 2'd0);
    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr_q <= ~wr_ptr_q;
            if (pop_ok)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: PC, synchronous-ROM requests, 2-deep skid buffer and IF/ID register.
// Optional FETCH_STATS_EN adds FetchCount/FlushCount statistics outputs.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int                    WORD_WIDTH = 32,
    parameter logic [WORD_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall,
    input  logic                  BranchEQ,
    input  logic                  BranchNE,
    input  logic                  Zero,
    input  logic [WORD_WIDTH-1:0] BranchTarget,
    output logic [WORD_WIDTH-1:0] InstrAddr,
    input  logic [WORD_WIDTH-1:0] InstrData,
    output logic [WORD_WIDTH-1:0] Instruction,
    output logic [WORD_WIDTH-1:0] PC_4,
    output logic                  InstrValid,
`ifdef FETCH_STATS_EN
    output logic [31:0]           FetchCount,
    output logic [15:0]           FlushCount,
`endif
    output logic [5:0]            OP
);

    localparam logic [WORD_WIDTH-1:0] STEP = WORD_WIDTH'(4);

    logic [WORD_WIDTH-1:0]   pc_q, pc_d;
    logic                    inflight_q, inflight_d;
    logic [WORD_WIDTH-1:0]   resp_pc4_q, resp_pc4_d;
    logic [WORD_WIDTH-1:0]   instr_q, instr_d;
    logic [WORD_WIDTH-1:0]   pc4_q, pc4_d;
    logic                    valid_q, valid_d;

    logic                    taken;
    logic                    issue;
    logic                    load;
    logic                    fifo_empty;
    logic                    bypass;
    logic                    push;
    logic                    pop;
    logic                    word_loaded;
    logic [1:0]              fifo_count;
    logic [1:0]              occupancy;
    logic [2*WORD_WIDTH-1:0] fifo_head;

    fetch_skid_fifo #(.DATA_W(2*WORD_WIDTH)) u_skid (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .push_dat_i ({resp_pc4_q, InstrData}),
        .pop_i      (pop),
        .clear_i    (taken),
        .head_dat_o (fifo_head),
        .count_o    (fifo_count)
    );

    assign taken      = branch_taken(BranchEQ, BranchNE, Zero);
    assign occupancy  = fifo_count + {1'b0, inflight_q};
    assign issue      = (occupancy < 2'd2) && !taken;
    assign load       = !Stall || !valid_q;
    assign fifo_empty = (fifo_count == 2'd0);
    // A returning word skips the buffer only when nothing older is queued ahead of it.
    assign bypass     = inflight_q && fifo_empty && load && !taken;
    assign push       = inflight_q && !bypass && !taken;
    assign pop        = load && !fifo_empty && !taken;
    assign word_loaded = load && !taken && (!fifo_empty || inflight_q);

    always_comb begin
        pc_d       = pc_q;
        inflight_d = 1'b0;
        resp_pc4_d = resp_pc4_q;
        instr_d    = instr_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;
        if (taken) begin
            pc_d    = BranchTarget;
            instr_d = NOP_WORD;
            valid_d = 1'b0;
        end else begin
            if (issue) begin
                inflight_d = 1'b1;
                pc_d       = pc_q + STEP;
                resp_pc4_d = pc_q + STEP;
            end
            if (load) begin
                if (!fifo_empty) begin
                    {pc4_d, instr_d} = fifo_head;
                    valid_d          = 1'b1;
                end else if (inflight_q) begin
                    pc4_d   = resp_pc4_q;
                    instr_d = InstrData;
                    valid_d = 1'b1;
                end else begin
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            resp_pc4_q <= '0;
            instr_q    <= NOP_WORD;
            pc4_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            resp_pc4_q <= resp_pc4_d;
            instr_q    <= instr_d;
            pc4_q      <= pc4_d;
            valid_q    <= valid_d;
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (word_loaded) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (taken && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign FetchCount = fetch_cnt_q;
    assign FlushCount = flush_cnt_q;
`else
    logic unused_word_loaded;
    assign unused_word_loaded = word_loaded;
`endif

    assign InstrAddr   = pc_q;
    assign Instruction = instr_q;
    assign PC_4        = pc4_q;
    assign InstrValid  = valid_q;
    assign OP          = instr_q[31:26];

endmodule
